// File: rtl/systolic_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// systolic_pkg : shared sizing defaults and feeder FSM state encoding
// Revision     : 1.0
// ----------------------------------------------------------------------------
package systolic_pkg;

   localparam int DATA_WIDTH_DFLT = 16;
   localparam int ARRAY_N_DFLT    = 4;
   localparam int K_MAX_DFLT      = 64;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LOAD  = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4
   } feeder_state_t;

   // Zero vectors needed after the last operand until PE(N-1,N-1) has its final product.
   function automatic int flush_len(input int n);
      return 2 * n + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_skew_feeder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// systolic_skew_feeder_if : operand/control bundle between upstream and feeder
// Revision                : 1.0
// ----------------------------------------------------------------------------
interface systolic_skew_feeder_if #(
   parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH_DFLT,
   parameter int ARRAY_N    = systolic_pkg::ARRAY_N_DFLT,
   parameter int K_MAX      = systolic_pkg::K_MAX_DFLT
) ();

   localparam int KW = $clog2(K_MAX + 1);

   logic                          start;
   logic [KW-1:0]                 k_len;
   logic                          busy;
   logic                          in_valid;
   logic                          in_ready;
   logic [ARRAY_N*DATA_WIDTH-1:0] a_in;
   logic [ARRAY_N*DATA_WIDTH-1:0] b_in;
   logic [ARRAY_N*DATA_WIDTH-1:0] a_out;
   logic [ARRAY_N*DATA_WIDTH-1:0] b_out;
   logic                          pe_reset;
   logic                          tile_done;

   modport master (
      output start, k_len, in_valid, a_in, b_in,
      input  busy, in_ready, a_out, b_out, pe_reset, tile_done
   );

   modport slave (
      input  start, k_len, in_valid, a_in, b_in,
      output busy, in_ready, a_out, b_out, pe_reset, tile_done
   );

endinterface
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// ----------------------------------------------------------------------------
// skew_delay_line : DEPTH-stage register pipeline with asynchronous clear
// Revision        : 1.0
// ----------------------------------------------------------------------------
module skew_delay_line #(
   parameter int DEPTH      = 1,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// systolic_skew_feeder : tile sequencer and diagonal operand skew for the array
// Revision             : 1.0
// ----------------------------------------------------------------------------
module systolic_skew_feeder #(
   parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH_DFLT,
   parameter int ARRAY_N    = systolic_pkg::ARRAY_N_DFLT,
   parameter int K_MAX      = systolic_pkg::K_MAX_DFLT
) (
   input  wire                    clk,
   input  wire                    reset,
   systolic_skew_feeder_if.slave  bus
);

   import systolic_pkg::*;

   localparam int KW        = $clog2(K_MAX + 1);
   localparam int FLUSH_LEN = flush_len(ARRAY_N);
   localparam int FW        = $clog2(FLUSH_LEN + 1);
   localparam int VW        = ARRAY_N * DATA_WIDTH;

   feeder_state_t state_q, state_d;
   logic [KW-1:0] k_len_q, k_len_d;
   logic [KW-1:0] acc_cnt_q, acc_cnt_d;
   logic [FW-1:0] flush_cnt_q, flush_cnt_d;
   logic          pe_reset_q;

   logic          xfer;
   logic [KW-1:0] k_clamped;
   logic [VW-1:0] stage0_a, stage0_b;
   wire  [VW-1:0] a_skew, b_skew;

   assign xfer      = bus.in_valid && (state_q == LOAD);
   assign k_clamped = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;

   // Non-transfer cycles inject zeros so the array accumulates nothing extra.
   assign stage0_a = xfer ? bus.a_in : '0;
   assign stage0_b = xfer ? bus.b_in : '0;

   always_comb begin
      state_d     = state_q;
      k_len_d     = k_len_q;
      acc_cnt_d   = acc_cnt_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               k_len_d   = k_clamped;
               acc_cnt_d = '0;
               state_d   = CLEAR;
            end
         end
         CLEAR: begin
            flush_cnt_d = '0;
            state_d     = (k_len_q == '0) ? FLUSH : LOAD;
         end
         LOAD: begin
            if (xfer) begin
               acc_cnt_d = acc_cnt_q + KW'(1);
               if (acc_cnt_d == k_len_q) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (flush_cnt_q == FW'(FLUSH_LEN - 1)) begin
               state_d = DONE;
            end else begin
               flush_cnt_d = flush_cnt_q + FW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         k_len_q     <= '0;
         acc_cnt_q   <= '0;
         flush_cnt_q <= '0;
         pe_reset_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_len_q     <= k_len_d;
         acc_cnt_q   <= acc_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         pe_reset_q  <= (state_d != CLEAR);
      end
   end

   for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
      skew_delay_line #(
         .DEPTH      (i + 1),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_a_dly (
         .clk   (clk),
         .reset (reset),
         .din   (stage0_a[i*DATA_WIDTH +: DATA_WIDTH]),
         .dout  (a_skew[i*DATA_WIDTH +: DATA_WIDTH])
      );

      skew_delay_line #(
         .DEPTH      (i + 1),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_b_dly (
         .clk   (clk),
         .reset (reset),
         .din   (stage0_b[i*DATA_WIDTH +: DATA_WIDTH]),
         .dout  (b_skew[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   assign bus.a_out     = a_skew;
   assign bus.b_out     = b_skew;
   assign bus.busy      = (state_q != IDLE);
   assign bus.in_ready  = (state_q == LOAD);
   assign bus.tile_done = (state_q == DONE);
   assign bus.pe_reset  = pe_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_systolic_skew_feeder : directed bench with skew history and PE-array model
// Revision                : 1.0
// ----------------------------------------------------------------------------
module tb_systolic_skew_feeder;

   localparam int DW = 16;
   localparam int N  = 4;
   localparam int KM = 64;
   localparam int KW = $clog2(KM + 1);
   localparam int VW = N * DW;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   systolic_skew_feeder_if #(.DATA_WIDTH(DW), .ARRAY_N(N), .K_MAX(KM)) bus_if ();

   systolic_skew_feeder #(.DATA_WIDTH(DW), .ARRAY_N(N), .K_MAX(KM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   // Stage-0 capture history, indexed by edge number relative to the tile start.
   logic [VW-1:0] hist_a [0:1023];
   logic [VW-1:0] hist_b [0:1023];
   int            cyc;
   int            n_xfer, done_cnt, pe_low;
   int            done_cyc;

   logic [DW-1:0] pa  [N][N];
   logic [DW-1:0] pb  [N][N];
   longint        acc [N][N];

   function automatic logic [VW-1:0] vec_a(input int idx);
      logic [VW-1:0] v;
      for (int r = 0; r < N; r++) v[r*DW +: DW] = DW'(r + 1 + 10 * idx);
      return v;
   endfunction

   function automatic logic [VW-1:0] vec_b(input int idx);
      logic [VW-1:0] v;
      for (int c = 0; c < N; c++) v[c*DW +: DW] = DW'(c + 1 + idx);
      return v;
   endfunction

   function automatic longint ref_dot(input int r, input int c, input int nx);
      longint s = 0;
      logic [VW-1:0] va, vb;
      for (int k = 0; k < nx; k++) begin
         va = vec_a(k);
         vb = vec_b(k);
         s += longint'(va[r*DW +: DW]) * longint'(vb[c*DW +: DW]);
      end
      return s;
   endfunction

   function automatic logic [VW-1:0] skew_exp(input bit sel_b, input int e);
      logic [VW-1:0] v;
      logic [VW-1:0] h;
      for (int i = 0; i < N; i++) begin
         if (e - i >= 0) begin
            h = sel_b ? hist_b[e-i] : hist_a[e-i];
            v[i*DW +: DW] = h[i*DW +: DW];
         end else begin
            v[i*DW +: DW] = '0;
         end
      end
      return v;
   endfunction

   task automatic clear_hist();
      cyc = 0;
      for (int i = 0; i < 1024; i++) begin
         hist_a[i] = '0;
         hist_b[i] = '0;
      end
      n_xfer   = 0;
      done_cnt = 0;
      pe_low   = 0;
      done_cyc = -1;
   endtask

   // Reference PE array: A moves right, B moves down, each PE accumulates A*B.
   task automatic pe_step();
      logic [VW-1:0] ao, bo;
      ao = bus_if.a_out;
      bo = bus_if.b_out;
      if (!bus_if.pe_reset) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               pa[r][c] = '0; pb[r][c] = '0; acc[r][c] = 0;
            end
      end else begin
         for (int r = 0; r < N; r++) begin
            for (int c = N - 1; c > 0; c--) pa[r][c] = pa[r][c-1];
            pa[r][0] = ao[r*DW +: DW];
         end
         for (int c = 0; c < N; c++) begin
            for (int r = N - 1; r > 0; r--) pb[r][c] = pb[r-1][c];
            pb[0][c] = bo[c*DW +: DW];
         end
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               acc[r][c] += longint'(pa[r][c]) * longint'(pb[r][c]);
      end
   endtask

   task automatic tick(input bit chk_skew);
      logic          x;
      logic [VW-1:0] sa, sb;
      x  = bus_if.in_valid && bus_if.in_ready;
      sa = x ? bus_if.a_in : '0;
      sb = x ? bus_if.b_in : '0;
      @(posedge clk);
      #1;
      if (cyc < 1023) cyc++;
      hist_a[cyc] = sa;
      hist_b[cyc] = sb;
      if (x) n_xfer++;
      if (bus_if.tile_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (!bus_if.pe_reset) pe_low++;
      if (chk_skew) begin
         check_eq($sformatf("a_skew@%0d", cyc), bus_if.a_out, skew_exp(1'b0, cyc));
         check_eq($sformatf("b_skew@%0d", cyc), bus_if.b_out, skew_exp(1'b1, cyc));
      end
      pe_step();
   endtask

   task automatic run_tile(input string name, input int klen, input int bubble_edge,
                           input int restart_edge, input int exp_done, input int exp_xfers);
      int guard;
      int e_next;
      clear_hist();
      bus_if.start    = 1'b1;
      bus_if.k_len    = KW'(klen);
      bus_if.in_valid = 1'b0;
      tick(1'b1);
      bus_if.start = 1'b0;
      check_eq({name, "_busy"}, bus_if.busy, 1);
      guard = 0;
      while (done_cnt == 0 && guard < 300) begin
         e_next          = cyc + 1;
         bus_if.start    = (e_next == restart_edge);
         bus_if.in_valid = (e_next != bubble_edge);
         bus_if.a_in     = vec_a(n_xfer);
         bus_if.b_in     = vec_b(n_xfer);
         tick(1'b1);
         guard++;
      end
      bus_if.start    = 1'b0;
      bus_if.in_valid = 1'b0;
      check_eq({name, "_done_edge"}, 64'(done_cyc), 64'(exp_done));
      check_eq({name, "_xfers"}, 64'(n_xfer), 64'(exp_xfers));
      check_eq({name, "_pe_reset_low_cycles"}, 64'(pe_low), 64'd1);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            check_eq($sformatf("%s_C[%0d][%0d]", name, r, c), acc[r][c], ref_dot(r, c, exp_xfers));
      tick(1'b1);
      check_eq({name, "_idle_busy"}, bus_if.busy, 0);
      check_eq({name, "_done_pulse_width"}, 64'(done_cnt), 64'd1);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      logic [VW-1:0] quiet;
      reset           = 1'b1;
      bus_if.start    = 1'b0;
      bus_if.k_len    = '0;
      bus_if.in_valid = 1'b0;
      bus_if.a_in     = '0;
      bus_if.b_in     = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_a_out",     bus_if.a_out, 0);
      check_eq("rst_b_out",     bus_if.b_out, 0);
      check_eq("rst_busy",      bus_if.busy, 0);
      check_eq("rst_in_ready",  bus_if.in_ready, 0);
      check_eq("rst_tile_done", bus_if.tile_done, 0);
      check_eq("rst_pe_reset",  bus_if.pe_reset, 0);
      reset = 1'b0;
      clear_hist();
      tick(1'b1);
      check_eq("pe_reset_after_first_edge", bus_if.pe_reset, 1);
      quiet = '0;
      repeat (10) begin
         tick(1'b1);
         quiet |= VW'({bus_if.busy, bus_if.tile_done, bus_if.in_ready});
      end
      check_eq("idle_quiet", quiet, 0);

      run_tile("basic",   3,  -1, -1, 14, 3);
      run_tile("bubble",  3,   4, -1, 15, 3);
      run_tile("klen0",   0,  -1, -1, 11, 0);

      // Abort a tile while it is flushing.
      clear_hist();
      bus_if.start = 1'b1;
      bus_if.k_len = KW'(3);
      tick(1'b1);
      bus_if.start = 1'b0;
      while (cyc < 8) begin
         bus_if.in_valid = 1'b1;
         bus_if.a_in     = vec_a(n_xfer);
         bus_if.b_in     = vec_b(n_xfer);
         tick(1'b1);
      end
      bus_if.in_valid = 1'b0;
      check_eq("pre_abort_a_out_nonzero", 64'(bus_if.a_out != '0), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("abort_a_out",     bus_if.a_out, 0);
      check_eq("abort_b_out",     bus_if.b_out, 0);
      check_eq("abort_busy",      bus_if.busy, 0);
      check_eq("abort_in_ready",  bus_if.in_ready, 0);
      check_eq("abort_tile_done", bus_if.tile_done, 0);
      check_eq("abort_pe_reset",  bus_if.pe_reset, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      clear_hist();
      repeat (15) tick(1'b1);
      check_eq("abort_no_tile_done", 64'(done_cnt), 64'd0);
      check_eq("abort_stays_idle", bus_if.busy, 0);

      run_tile("after_abort", 3, -1, -1, 14, 3);
      run_tile("clamp", KM + 5, -1, 10, KM + 11, KM);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream operand feeder for the 2D FP16 systolic array. It accepts one N-lane A column-slice and one N-lane B row-slice per handshake. It re-times lane i by i extra cycles, producing the diagonal wavefront that the edge ProcessingElements consume. It also clears the PE accumulators before each tile, flushes the array with zeros after the last operand, and pulses `tile_done` once every PE_out holds its final dot product.

## Interface
- `DATA_WIDTH`, 16, FP16 operand width
- `ARRAY_N`, 4, array dimension (lanes per side)
- `K_MAX`, 64, maximum operand vectors per tile
- `clk`  in  1  clock
- `reset`  in  1  reset; one clock, reset is asynchronous and active-high
- `start`  in  1  begin tile; sampled only in IDLE
- `k_len`  in  $clog2(K_MAX+1)  vectors in tile, sampled with `start`
- `busy`  out  1  high in any state except IDLE
- `in_valid`  in  1  operand vector valid
- `in_ready`  out  1  feeder can accept (LOAD only)
- `a_in`  in  ARRAY_N*DATA_WIDTH  A lanes, lane i at bits [i*DW +: DW]
- `b_in`  in  ARRAY_N*DATA_WIDTH  B lanes, same packing
- `a_out`  out  ARRAY_N*DATA_WIDTH  skewed A to row-edge PEs (Current_A)
- `b_out`  out  ARRAY_N*DATA_WIDTH  skewed B to column-edge PEs (Current_B)
- `pe_reset`  out  1  active-low clear to all PEs (matches PE reset port)
- `tile_done`  out  1  one-cycle pulse: all PE_out final

## Operation
- States: IDLE, CLEAR, LOAD, FLUSH, DONE.
- IDLE: `start`=1 latches `k_len`, goes to CLEAR. `start` in any other state is ignored.
- Clamping: `k_len` > K_MAX is clamped to K_MAX.
- CLEAR (1 cycle): `pe_reset`=0. Next state is LOAD, or FLUSH if `k_len`=0.
- LOAD:
  - `in_ready`=1.
  - Transfer = `in_valid` & `in_ready` at a rising edge.
  - An accept counter increments per transfer.
  - On the k_len-th transfer, go to FLUSH.
  - Cycles without a transfer are bubbles. A bubble shifts an all-zero vector into every lane; zeros pair with zeros, so the accumulated result is unchanged.
- FLUSH: exactly 2*ARRAY_N+1 cycles. `in_ready`=0. Zeros are shifted in. Then go to DONE.
- DONE (1 cycle): `tile_done`=1, then IDLE.
- Skew:
  - Lane i of `a_out`/`b_out` equals the lane-i value shifted in exactly i+1 rising edges earlier.
  - The stage-0 input is `a_in`/`b_in` on a transfer edge, zero otherwise.
  - Every lane shifts every cycle in all states, so zeros keep draining.
- `pe_reset` is registered: 0 while `reset` is high and during CLEAR, 1 otherwise.
- No arithmetic on operand data; bits pass through unchanged.

## Timing
- Reset values:
  - state = IDLE
  - `busy`=0, `in_ready`=0, `tile_done`=0, `pe_reset`=0
  - `a_out` = `b_out` = 0; all shift registers and counters = 0
- Reset asserted mid-tile aborts immediately to the reset values. No `tile_done` is produced.
- `start` at edge 0: CLEAR occupies cycle 1, LOAD begins at edge 2, `in_ready` is high from edge 2.
- `in_ready` is a state decode; it does not depend combinationally on `in_valid`.
- Last transfer at edge c:
  - FLUSH spans edges c..c+2N+1.
  - `tile_done` is high for the cycle after edge c+2N+1.
  - At that point PE(N-1,N-1) has absorbed its last product, so all PE_out are stable.
- Total latency with no bubbles, from `start` edge 0: `tile_done` is high after edge k_len+2N+3 (k_len ≥ 1).
- Back-to-back tiles: `start` may be asserted in the cycle `tile_done` is high only if the state is already IDLE at the next edge. `start` is accepted one cycle after DONE.

## Structure
- Shared package `systolic_pkg`: DATA_WIDTH, ARRAY_N, K_MAX defaults, and the `feeder_state_t` enum (IDLE, CLEAR, LOAD, FLUSH, DONE).
- Sub-module `skew_delay_line`:
  - Parameters DEPTH, DATA_WIDTH; ports clk, reset, din, dout.
  - DEPTH registers with asynchronous clear.
  - Instantiated 2*ARRAY_N times with DEPTH=i+1.
- Top level holds the FSM, the accept counter, the flush counter, and the `pe_reset` register.

## Test plan
- Reset, then idle for 10 cycles -> all outputs 0, `pe_reset` goes 1 after the first edge with reset low, `busy`=0.
- N=4, k_len=3, A lanes {1,2,3,4}+10*k, continuous `in_valid` -> `a_out` lane i shows values exactly i+1 cycles after transfer; `pe_reset` low exactly one cycle; `tile_done` high after edge 3+2*4+3=14.
- Same tile with `in_valid` low on the 2nd LOAD cycle -> one zero bubble in each lane; `tile_done` one cycle later (after edge 15); full PE array model yields the identical matrix product.
- k_len=0 -> CLEAR, then 9 FLUSH cycles, `tile_done` after edge 11; PE results all 0.
- `reset` asserted during FLUSH -> immediate zero outputs, state IDLE, no `tile_done`; next `start` runs a clean tile.
- `start` pulsed during LOAD, and k_len=K_MAX+5 -> mid-tile `start` ignored; tile completes after exactly K_MAX transfers.
